// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: default datapath sizing and condition-code encodings.
package lc3_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

endpackage

// File: rtl/nzp_gen.sv
// Combinational N/Z/P classifier of a signed data word; always one-hot.
module nzp_gen
    import lc3_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic [2:0]       nzp
);

    always_comb begin
        if (data[WIDTH-1])
            nzp = CC_N;
        else if (data == '0)
            nzp = CC_Z;
        else
            nzp = CC_P;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two bypassed read ports, a per-register busy scoreboard
// for destination reservation, and NZP condition codes loaded on writeback.
module reg_file_sb
    import lc3_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             set_cc,
    input  logic [AW-1:0]    rd1_addr,
    input  logic [AW-1:0]    rd2_addr,
    output logic [WIDTH-1:0] rd1_data,
    output logic [WIDTH-1:0] rd2_data,
    output logic             busy1,
    output logic             busy2,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ok,
    output logic [2:0]       cc,
    output logic             any_busy
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [2:0]       wr_nzp;
    logic             byp1;
    logic             byp2;

    nzp_gen #(.WIDTH(WIDTH)) u_nzp_gen (
        .data (wr_data),
        .nzp  (wr_nzp)
    );

    // Forwarding is suppressed during reset so reads return the cleared contents.
    assign byp1 = rst_n && wr_en && (wr_addr == rd1_addr);
    assign byp2 = rst_n && wr_en && (wr_addr == rd2_addr);

    assign rd1_data = byp1 ? wr_data : regs[rd1_addr];
    assign rd2_data = byp2 ? wr_data : regs[rd2_addr];
    assign busy1    = busy[rd1_addr] && !byp1;
    assign busy2    = busy[rd2_addr] && !byp2;
    assign any_busy = |busy;

    assign rsv_ok = rst_n && rsv_en &&
                    (!busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

    // Set after clear: a reservation landing on the same edge as the write wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[wr_addr] = 1'b0;
        if (rsv_ok)
            busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy <= '0;
            cc   <= CC_Z;
        end else begin
            if (wr_en)
                regs[wr_addr] <= wr_data;
            if (wr_en && set_cc)
                cc <= wr_nzp;
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed checks of reg_file_sb at default size and at WIDTH=32, NREGS=16.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          failures = 0;

    // default-size instance
    logic        wr_en, set_cc, rsv_en;
    logic [2:0]  wr_addr, rd1_addr, rd2_addr, rsv_addr;
    logic [15:0] wr_data, rd1_data, rd2_data;
    logic        busy1, busy2, rsv_ok, any_busy;
    logic [2:0]  cc;

    // wide instance
    logic        b_wr_en, b_set_cc, b_rsv_en;
    logic [3:0]  b_wr_addr, b_rd1_addr, b_rd2_addr, b_rsv_addr;
    logic [31:0] b_wr_data, b_rd1_data, b_rd2_data;
    logic        b_busy1, b_busy2, b_rsv_ok, b_any_busy;
    logic [2:0]  b_cc;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .set_cc(set_cc), .rd1_addr(rd1_addr),
        .rd2_addr(rd2_addr), .rd1_data(rd1_data), .rd2_data(rd2_data),
        .busy1(busy1), .busy2(busy2), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(rsv_ok), .cc(cc), .any_busy(any_busy)
    );

    reg_file_sb #(.WIDTH(32), .NREGS(16)) dut_big (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .set_cc(b_set_cc), .rd1_addr(b_rd1_addr),
        .rd2_addr(b_rd2_addr), .rd1_data(b_rd1_data), .rd2_data(b_rd2_data),
        .busy1(b_busy1), .busy2(b_busy2), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
        .rsv_ok(b_rsv_ok), .cc(b_cc), .any_busy(b_any_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic scc);
        wr_en = 1'b1; wr_addr = a; wr_data = d; set_cc = scc;
        tick();
        wr_en = 1'b0; set_cc = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 0; set_cc = 0; rsv_en = 1; wr_addr = 0; wr_data = 16'h1234;
        rd1_addr = 0; rd2_addr = 0; rsv_addr = 0;
        b_wr_en = 0; b_set_cc = 0; b_rsv_en = 0; b_wr_addr = 0; b_wr_data = 0;
        b_rd1_addr = 0; b_rd2_addr = 0; b_rsv_addr = 0;

        // reset held for 3 cycles, with a write and a reservation pending
        repeat (3) tick();
        wr_en = 1'b1; rd2_addr = 3'd1;
        #1;
        chk("rst_rd1_no_bypass", rd1_data, 16'h0000);
        chk("rst_rd2", rd2_data, 16'h0000);
        chk("rst_cc", cc, 3'b010);
        chk("rst_any_busy", any_busy, 1'b0);
        chk("rst_rsv_ok", rsv_ok, 1'b0);
        chk("rst_busy1", busy1, 1'b0);
        wr_en = 1'b0; rsv_en = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_any_busy", any_busy, 1'b0);

        // write then read, and same-cycle bypass
        wr(3'd3, 16'h0069, 1'b0);
        rd1_addr = 3'd3;
        #1;
        chk("rd1_r3", rd1_data, 16'h0069);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd2_addr = 3'd5;
        #1;
        chk("bypass_rd2_r5", rd2_data, 16'hBEEF);
        chk("bypass_rd1_unaffected", rd1_data, 16'h0069);
        tick();
        wr_en = 1'b0;
        #1;
        chk("stored_r5", rd2_data, 16'hBEEF);
        chk("cc_hold_no_setcc", cc, 3'b010);

        // scoreboard reserve / refuse / clear
        rsv_en = 1'b1; rsv_addr = 3'd2;
        #1;
        chk("rsv_r2_ok", rsv_ok, 1'b1);
        tick();
        rsv_en = 1'b0; rd1_addr = 3'd2;
        #1;
        chk("busy1_r2", busy1, 1'b1);
        chk("any_busy_r2", any_busy, 1'b1);
        rsv_en = 1'b1;
        #1;
        chk("rsv_r2_refused", rsv_ok, 1'b0);
        tick();
        rsv_en = 1'b0;
        #1;
        chk("busy1_r2_after_refuse", busy1, 1'b1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0001;
        #1;
        chk("busy1_clear_bypass", busy1, 1'b0);
        chk("any_busy_not_bypassed", any_busy, 1'b1);
        tick();
        wr_en = 1'b0;
        #1;
        chk("any_busy_after_wr", any_busy, 1'b0);
        chk("rd1_r2", rd1_data, 16'h0001);

        // write to non-busy register keeps busy clear
        wr(3'd6, 16'h0042, 1'b0);
        rd2_addr = 3'd6;
        #1;
        chk("busy2_r6_nonbusy_wr", busy2, 1'b0);

        // simultaneous write and reservation on busy R4
        rsv_en = 1'b1; rsv_addr = 3'd4;
        tick();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0004;
        #1;
        chk("rsv_ok_r4_with_wr", rsv_ok, 1'b1);
        tick();
        wr_en = 1'b0; rsv_en = 1'b0; rd1_addr = 3'd4;
        #1;
        chk("busy1_r4_held", busy1, 1'b1);
        chk("rd1_r4", rd1_data, 16'h0004);
        wr(3'd4, 16'h0005, 1'b0);
        chk("any_busy_r4_cleared", any_busy, 1'b0);

        // condition codes
        wr(3'd0, 16'h8000, 1'b1);
        chk("cc_neg", cc, 3'b100);
        wr(3'd0, 16'h0000, 1'b1);
        chk("cc_zero", cc, 3'b010);
        wr(3'd0, 16'h7FFF, 1'b1);
        chk("cc_pos", cc, 3'b001);
        wr(3'd0, 16'hFFFF, 1'b0);
        chk("cc_hold", cc, 3'b001);

        // mid-operation reset discards pending state
        rsv_en = 1'b1; rsv_addr = 3'd1;
        tick();
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777; rsv_addr = 3'd7;
        rst_n = 1'b0;
        rd1_addr = 3'd3;
        #1;
        chk("midrst_any_busy", any_busy, 1'b0);
        chk("midrst_rd1", rd1_data, 16'h0000);
        chk("midrst_cc", cc, 3'b010);
        tick();
        wr_en = 1'b0; rsv_en = 1'b0; rst_n = 1'b1;
        tick();
        rd1_addr = 3'd7;
        #1;
        chk("midrst_r7_discarded", rd1_data, 16'h0000);
        chk("midrst_busy1_r7", busy1, 1'b0);

        // wide instance
        b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 32'hFFFFFFFF; b_set_cc = 1'b1;
        tick();
        b_wr_en = 1'b0; b_set_cc = 1'b0; b_rd1_addr = 4'd15;
        #1;
        chk("big_rd1_r15", b_rd1_data, 32'hFFFFFFFF);
        chk("big_cc_neg", b_cc, 3'b100);
        b_rsv_en = 1'b1; b_rsv_addr = 4'd15;
        tick();
        b_rsv_en = 1'b0;
        #1;
        chk("big_busy1_r15", b_busy1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("big_rst_busy1", b_busy1, 1'b0);
        chk("big_rst_any_busy", b_any_busy, 1'b0);
        chk("big_rst_rd1", b_rd1_data, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("big_post_rst_cc", b_cc, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width in bits.
REQ-002 The block SHALL have parameter NREGS, default 8, giving the register count (power of two, >= 2).
REQ-003 The block SHALL derive local constant AW = clog2(NREGS) as the register address width.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 wr_en  input  1  writeback strobe.
REQ-007 wr_addr  input  AW  writeback destination register.
REQ-008 wr_data  input  WIDTH  writeback value.
REQ-009 set_cc  input  1  when set with wr_en, the write also updates the condition codes.
REQ-010 rd1_addr, rd2_addr  input  AW each  read-port addresses.
REQ-011 rd1_data, rd2_data  output  WIDTH each  read-port data.
REQ-012 busy1, busy2  output  1 each  scoreboard status of rd1_addr and rd2_addr.
REQ-013 rsv_en  input  1  request to reserve a destination register.
REQ-014 rsv_addr  input  AW  register to reserve.
REQ-015 rsv_ok  output  1  reservation accepted this cycle.
REQ-016 cc  output  3  condition codes {N,Z,P}.
REQ-017 any_busy  output  1  at least one scoreboard bit is set.

Function
REQ-018 Register write: on a clock edge with wr_en=1, the block SHALL store wr_data into reg[wr_addr].
REQ-019 Read ports: rdN_data SHALL be combinational, equal to reg[rdN_addr].
REQ-020 Read bypass: when wr_en=1 and wr_addr==rdN_addr, rdN_data SHALL equal wr_data in the same cycle (zero-latency forwarding).
REQ-021 Scoreboard: the block SHALL hold one busy bit per register.
REQ-022 An accepted reservation SHALL set busy[rsv_addr] at the next edge.
REQ-023 wr_en SHALL clear busy[wr_addr] at the next edge.
REQ-024 rsv_ok SHALL be combinational and equal rsv_en AND (NOT busy[rsv_addr] OR (wr_en AND wr_addr==rsv_addr)).
REQ-025 A refused reservation (rsv_en=1, rsv_ok=0) SHALL change no state; the requester holds or retries.
REQ-026 On the same edge, an accepted reservation and a write to the same register SHALL leave busy set (reservation wins).
REQ-027 busyN SHALL equal busy[rdN_addr] AND NOT (wr_en AND wr_addr==rdN_addr), so that the clear is bypassed.
REQ-028 A write to a non-busy register SHALL be legal and SHALL leave its busy bit 0.
REQ-029 Condition codes: on an edge with wr_en=1 and set_cc=1, cc SHALL load:
  - 100 if wr_data[WIDTH-1]=1;
  - 010 if wr_data==0;
  - 001 otherwise.
REQ-030 cc SHALL otherwise hold its value.
REQ-031 Exactly one bit of cc SHALL be set at all times.
REQ-032 any_busy SHALL be the OR of the registered busy bits; it SHALL NOT be bypassed.

Reset
REQ-033 While rst_n=0, all registers SHALL be 0, all busy bits 0 and cc=010, asynchronously.
REQ-034 While rst_n=0, the outputs SHALL be:
  - rsv_ok=0 regardless of rsv_en;
  - any_busy=0, busy1=0, busy2=0;
  - rd1_data and rd2_data = 0 (no bypass).
REQ-035 Reset asserted mid-operation SHALL discard pending reservations and writes on that edge.
REQ-036 Normal operation SHALL resume on the first rising clk edge after rst_n rises.

Structure
REQ-037 The shared package lc3_pkg SHALL hold:
  - default WIDTH (16) and NREGS (8);
  - CC encodings CC_N=100, CC_Z=010, CC_P=001.
REQ-038 NZP generation SHALL be the sub-module nzp_gen (combinational, parametrised by WIDTH), reused later by the datapath.
REQ-039 Storage and scoreboard SHALL stay in reg_file_sb, with no further sub-modules.

Verification
REQ-040 Reset: rst_n low for 3 cycles -> all reads 0, cc=010, any_busy=0, rsv_ok=0 with rsv_en=1.
REQ-041 Write/read: write R3=0x0069 -> next cycle rd1_addr=3 gives 0x0069; the same-cycle bypass of R5=0xBEEF gives rd2_data=0xBEEF during the write cycle.
REQ-042 Scoreboard: reserve R2 -> busy1=1 for rd1_addr=2; a second reserve of R2 gives rsv_ok=0; write R2=0x0001 -> busy1=0 in the write cycle, and any_busy=0 after it.
REQ-043 Simultaneous events: with R4 busy, write R4 plus reserve R4 in the same cycle -> rsv_ok=1, and R4 remains busy next cycle.
REQ-044 CC: writes with set_cc of 0x8000, 0x0000 and 0x7FFF give cc=100, 010, 001; a write of 0xFFFF with set_cc=0 leaves cc=001.
REQ-045 Parameters: WIDTH=32, NREGS=16 -> R15=0xFFFFFFFF reads back and gives cc=100; mid-test reset clears busy on R15.
